// File: rtl/vec_lane_sequencer.sv
// Sequences a LANES-wide vector op (or 1-lane scalar) through one shared XLEN ALU; optional flush port under VEC_SEQ_FLUSH_EN.
// Latency: accept at T, done at T+2 (scalar) or T+LANES+1 (vector); back-to-back accept allowed in the DONE cycle.
// Backpressure: StallE holds upstream from the accept cycle through the last lane beat; start during a busy op is ignored.
module vec_lane_sequencer #(
    parameter int XLEN  = 32,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_vectorial,
    input  logic [2:0]              ALUControlE,
    input  logic [XLEN*LANES-1:0]   SrcA_E,
    input  logic [XLEN*LANES-1:0]   SrcB_E,
    input  logic [5:0]              RD_E,
`ifdef VEC_SEQ_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    output logic [2:0]              alu_ctrl,
    input  logic [XLEN-1:0]         alu_result,
    output logic                    StallE,
    output logic                    done,
    output logic [XLEN*LANES-1:0]   result_o,
    output logic [5:0]              RD_out,
    output logic                    zero_all
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LANE = 2'd1,
        DONE = 2'd2
    } seqState_t;

    seqState_t                      state;
    seqState_t                      stateNext;

    logic [LANES-1:0][XLEN-1:0]     opA;
    logic [LANES-1:0][XLEN-1:0]     opB;
    logic [LANES-1:0][XLEN-1:0]     acc;
    logic [LANES-1:0][XLEN-1:0]     accNext;
    logic [5:0]                     rdCap;
    logic [LW-1:0]                  idx;
    logic [LW-1:0]                  lastIdx;
    logic                           flushInt;
    logic                           accept;
    logic                           lastBeat;

`ifdef VEC_SEQ_FLUSH_EN
    assign flushInt = flush;
`else
    assign flushInt = 1'b0;
`endif

    assign accept   = ((state == IDLE) || (state == DONE)) && start && !flushInt;
    assign lastBeat = (idx == lastIdx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (accept) stateNext = LANE;
            LANE:    if (lastBeat) stateNext = DONE;
            DONE:    stateNext = accept ? LANE : IDLE;
            default: stateNext = IDLE;
        endcase
        if (flushInt) begin
            stateNext = IDLE;
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        if (state == LANE) begin
            alu_a = opA[idx];
            alu_b = opB[idx];
        end
        done   = (state == DONE) && !flushInt;
        // Gated by reset so a held start cannot raise a stall while the block is in reset.
        StallE = rst && !flushInt && (((state == IDLE) && start) || (state == LANE));
    end

    always_comb begin
        accNext      = acc;
        accNext[idx] = alu_result;
    end

    // Outputs load only on the final beat so they stay stable across a back-to-back accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opA      <= '0;
            opB      <= '0;
            acc      <= '0;
            rdCap    <= '0;
            idx      <= '0;
            lastIdx  <= '0;
            alu_ctrl <= '0;
            result_o <= '0;
            RD_out   <= '0;
            zero_all <= 1'b0;
        end else if (accept) begin
            opA      <= SrcA_E;
            opB      <= SrcB_E;
            alu_ctrl <= ALUControlE;
            rdCap    <= RD_E;
            lastIdx  <= is_vectorial ? LW'(LANES - 1) : '0;
            idx      <= '0;
            acc      <= '0;
        end else if ((state == LANE) && !flushInt) begin
            acc <= accNext;
            idx <= idx + LW'(1);
            if (lastBeat) begin
                result_o <= accNext;
                RD_out   <= rdCap;
                zero_all <= (accNext == '0);
            end
        end
    end

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed bench for vec_lane_sequencer: table of ops plus hand sequences for reset, back-to-back and abort.
module tb_vec_lane_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_vectorial = 1'b0;
    logic [2:0]   ALUControlE = '0;
    logic [127:0] SrcA_E = '0;
    logic [127:0] SrcB_E = '0;
    logic [5:0]   RD_E = '0;
`ifdef VEC_SEQ_FLUSH_EN
    logic         flush = 1'b0;
`endif
    logic [31:0]  alu_a, alu_b, alu_result;
    logic [2:0]   alu_ctrl;
    logic         StallE, done, zero_all;
    logic [127:0] result_o;
    logic [5:0]   RD_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_lane_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .is_vectorial(is_vectorial),
        .ALUControlE(ALUControlE), .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .RD_E(RD_E),
`ifdef VEC_SEQ_FLUSH_EN
        .flush(flush),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .StallE(StallE), .done(done), .result_o(result_o), .RD_out(RD_out), .zero_all(zero_all)
    );

    // Shared ALU the sequencer drives.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic         vec;
        logic [2:0]   ctrl;
        logic [127:0] a;
        logic [127:0] b;
        logic [5:0]   rd;
        logic [127:0] res;
        logic         z;
        int           lat;
    } vecT;

    vecT tbl[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic present(input logic vec, input logic [2:0] ctrl, input logic [127:0] a,
                           input logic [127:0] b, input logic [5:0] rd);
        start = 1'b1;
        is_vectorial = vec;
        ALUControlE = ctrl;
        SrcA_E = a;
        SrcB_E = b;
        RD_E = rd;
    endtask

    initial begin
        int lat;
        logic stallOk;
        logic sawDone;

        tbl[0] = '{1'b0, 3'b000, 128'd10, 128'd20, 6'd1, 128'd30, 1'b0, 2};
        tbl[1] = '{1'b0, 3'b000, 128'hDEADBEEF_CAFEF00D_11111111_00000005,
                   128'h01234567_89ABCDEF_22222222_00000007, 6'd2, 128'd12, 1'b0, 2};
        tbl[2] = '{1'b1, 3'b000, 128'h00000001_00000002_00000003_00000004,
                   128'h00000001_00000002_00000003_00000004, 6'd3,
                   128'h00000002_00000004_00000006_00000008, 1'b0, 5};
        tbl[3] = '{1'b1, 3'b001, 128'h00000032_00000032_00000032_00000032,
                   128'h00000032_00000032_00000032_00000032, 6'd4, 128'd0, 1'b1, 5};
        tbl[4] = '{1'b0, 3'b001, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000005,
                   128'd5, 6'd63, 128'd0, 1'b1, 2};
        tbl[5] = '{1'b1, 3'b100, 128'h12345678_9ABCDEF0_0F0F0F0F_FFFFFFFF,
                   128'h12345678_00000000_F0F0F0F0_0000FFFF, 6'd10,
                   128'h00000000_9ABCDEF0_FFFFFFFF_FFFF0000, 1'b0, 5};
        tbl[6] = '{1'b1, 3'b011, 128'h00000001_00000000_00000000_00000000,
                   128'd0, 6'd33, 128'h00000001_00000000_00000000_00000000, 1'b0, 5};
        tbl[7] = '{1'b1, 3'b010, 128'hFFFFFFFF_0000FFFF_12345678_80000000,
                   128'h0F0F0F0F_FFFF0000_FFFFFFFF_80000001, 6'd17,
                   128'h0F0F0F0F_00000000_12345678_80000000, 1'b0, 5};

        // Reset held with start asserted
        present(1'b1, 3'b000, 128'h5, 128'h6, 6'd9);
        repeat (2) @(negedge clk);
        chk("rst_stall", StallE, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", RD_out, 0);
        chk("rst_zero", zero_all, 0);
        chk("rst_alu_a", alu_a, 0);

        // First accept on the first edge after release
        rst = 1'b1;
        present(1'b0, 3'b000, 128'd3, 128'd4, 6'd7);
        #1 chk("first_stall", StallE, 1);
        @(negedge clk);
        start = 1'b0;
        chk("first_alu_a", alu_a, 3);
        @(negedge clk);
        chk("first_done", done, 1);
        chk("first_result", result_o, 7);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            present(tbl[i].vec, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].rd);
            #1 chk($sformatf("v%0d_accept_stall", i), StallE, 1);
            @(negedge clk);
            start = 1'b0;
            lat = 1;
            stallOk = 1'b1;
            while (done !== 1'b1 && lat < 20) begin
                if (StallE !== 1'b1) stallOk = 1'b0;
                @(negedge clk);
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_busy_stall", i), stallOk, 1);
            chk($sformatf("v%0d_done_stall", i), StallE, 0);
            chk($sformatf("v%0d_result", i), result_o, tbl[i].res);
            chk($sformatf("v%0d_rd", i), RD_out, tbl[i].rd);
            chk($sformatf("v%0d_zero", i), zero_all, tbl[i].z);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_hold", i), result_o, tbl[i].res);
        end

        // Idle: ALU operands zero, opcode held from last op
        chk("idle_alu_a", alu_a, 0);
        chk("idle_alu_ctrl", alu_ctrl, 3'b010);

        // Lane issue order
        present(1'b1, 3'b000, 128'h00000001_00000002_00000003_00000004,
                128'h00000010_00000020_00000030_00000040, 6'd5);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("beat%0d_alu_a", k), alu_a, 4 - k);
            chk($sformatf("beat%0d_alu_b", k), alu_b, 64 - 16 * k);
            @(negedge clk);
        end
        chk("order_done", done, 1);
        chk("order_result", result_o, 128'h00000011_00000022_00000033_00000044);
        @(negedge clk);

        // Back-to-back: start held through the busy op, next op taken in DONE
        present(1'b1, 3'b000, 128'h00000001_00000002_00000003_00000004,
                128'h00000001_00000002_00000003_00000004, 6'd5);
        @(negedge clk);
        present(1'b0, 3'b000, 128'd100, 128'd23, 6'd9);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", lat, 5);
        chk("b2b_first_result", result_o, 128'h00000002_00000004_00000006_00000008);
        chk("b2b_first_rd", RD_out, 5);
        chk("b2b_done_stall", StallE, 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_lane_alu_a", alu_a, 100);
        chk("b2b_result_hold", result_o, 128'h00000002_00000004_00000006_00000008);
        @(negedge clk);
        chk("b2b_second_done", done, 1);
        chk("b2b_second_result", result_o, 128'd123);
        chk("b2b_second_rd", RD_out, 9);
        @(negedge clk);

`ifdef VEC_SEQ_FLUSH_EN
        // Flush at lane index 2
        present(1'b1, 3'b000, 128'h00000001_00000002_00000003_00000004,
                128'h00000001_00000002_00000003_00000004, 6'd6);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("flush_beat2_alu_a", alu_a, 2);
        flush = 1'b1;
        #1 chk("flush_stall", StallE, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_alu_a", alu_a, 0);
        sawDone = 1'b0;
        repeat (8) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", sawDone, 0);
        chk("flush_result_kept", result_o, 128'd123);
        chk("flush_rd_kept", RD_out, 9);

        // Flush wins over start in IDLE
        present(1'b0, 3'b000, 128'd1, 128'd1, 6'd2);
        flush = 1'b1;
        #1 chk("flush_start_stall", StallE, 0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        chk("flush_start_ignored", alu_a, 0);
        @(negedge clk);
`endif

        // Asynchronous reset mid-op at lane index 1
        present(1'b1, 3'b000, 128'h00000001_00000002_00000003_00000004,
                128'h00000001_00000002_00000003_00000004, 6'd8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst_beat1_alu_a", alu_a, 3);
        rst = 1'b0;
        #1;
        chk("midrst_stall", StallE, 0);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_result", result_o, 0);
        chk("midrst_rd", RD_out, 0);
        @(negedge clk);
        rst = 1'b1;
        sawDone = 1'b0;
        repeat (8) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", sawDone, 0);
        chk("midrst_result_after", result_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
